// File: rtl/branch_predictor_pkg.sv
// Shared branch-predictor types and control-flow kind encoding.
// Imported by the predictor top and its return-address stack.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    BP_KIND_COND = 2'd0,
    BP_KIND_JUMP = 2'd1,
    BP_KIND_CALL = 2'd2,
    BP_KIND_RET  = 2'd3
  } bp_kind_e;

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack; a push when full drops the oldest entry.
// Top is combinational from the registered stack.
module bp_ras #(
  parameter int DATA_LEN = 32,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [DATA_LEN-1:0] push_data,
  output logic [DATA_LEN-1:0] top,
  output logic                empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [DATA_LEN-1:0] stk_q [DEPTH];
  logic [PW-1:0]       sp_q, sp_d;
  logic [PW:0]         cnt_q, cnt_d;
  logic [PW-1:0]       top_idx;

  always_comb begin
    top_idx = sp_q - PW'(1);
    top     = stk_q[top_idx];
    empty   = (cnt_q == '0);
  end

  // sp wraps naturally since DEPTH is a power of two
  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (push) begin
      sp_d = sp_q + PW'(1);
      if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
    end else if (pop && cnt_q != '0) begin
      sp_d  = sp_q - PW'(1);
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stk_q[sp_q] <= push_data;
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating counters plus a return-address stack.
// Lookup is combinational; EX updates land on the rising edge.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int DATA_LEN  = 32,
  parameter int ENTRIES   = 64,
  parameter int CNT_BITS  = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_LEN-1:0] if_pc,
  output logic                pred_taken,
  output logic [DATA_LEN-1:0] pred_target,
  input  logic                upd_valid,
  input  logic [DATA_LEN-1:0] upd_pc,
  input  logic [1:0]          upd_kind,
  input  logic                upd_taken,
  input  logic [DATA_LEN-1:0] upd_target,
  input  logic                upd_pred_taken,
  input  logic [DATA_LEN-1:0] upd_pred_target,
  output logic                mispredict
);

  localparam int IDX     = $clog2(ENTRIES);
  localparam int TAG_LEN = DATA_LEN - 2 - IDX;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_WT  =
    CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - 1'b1;

  logic                valid_q [ENTRIES];
  logic [TAG_LEN-1:0]  tag_q   [ENTRIES];
  logic [DATA_LEN-1:0] tgt_q   [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q   [ENTRIES];
  bp_kind_e            kind_q  [ENTRIES];

  logic [IDX-1:0]      lk_idx, up_idx;
  logic [TAG_LEN-1:0]  lk_tag, up_tag;
  logic                lk_hit, up_hit, up_cond;
  logic [DATA_LEN-1:0] pc_plus4;

  logic                wr_en;
  logic [CNT_BITS-1:0] cnt_d;
  logic [DATA_LEN-1:0] tgt_d;
  bp_kind_e            kind_d;

  logic                ras_push, ras_pop, ras_empty;
  logic [DATA_LEN-1:0] ras_top, ras_data;

  assign lk_idx   = if_pc[IDX+1:2];
  assign lk_tag   = if_pc[DATA_LEN-1:IDX+2];
  assign up_idx   = upd_pc[IDX+1:2];
  assign up_tag   = upd_pc[DATA_LEN-1:IDX+2];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_cond  = (upd_kind == BP_KIND_COND);
  assign pc_plus4 = if_pc + DATA_LEN'(4);

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = pc_plus4;
    if (!reset && lk_hit) begin
      unique case (kind_q[lk_idx])
        BP_KIND_COND: begin
          pred_taken = cnt_q[lk_idx][CNT_BITS-1];
          if (pred_taken) pred_target = tgt_q[lk_idx];
        end
        BP_KIND_JUMP, BP_KIND_CALL: begin
          pred_taken  = 1'b1;
          pred_target = tgt_q[lk_idx];
        end
        BP_KIND_RET: begin
          pred_taken = !ras_empty;
          if (!ras_empty) pred_target = ras_top;
        end
      endcase
    end
  end

  always_comb begin
    wr_en  = 1'b0;
    cnt_d  = cnt_q[up_idx];
    tgt_d  = tgt_q[up_idx];
    kind_d = bp_kind_e'(upd_kind);
    if (upd_valid) begin
      unique case (1'b1)
        up_cond && up_hit: begin
          wr_en = 1'b1;
          if (upd_taken) begin
            tgt_d = upd_target;
            if (cnt_q[up_idx] != CNT_MAX) cnt_d = cnt_q[up_idx] + 1'b1;
          end else if (cnt_q[up_idx] != '0) begin
            cnt_d = cnt_q[up_idx] - 1'b1;
          end
        end
        up_cond && !up_hit: begin
          wr_en = upd_taken;
          cnt_d = CNT_WT;
          tgt_d = upd_target;
        end
        default: begin
          wr_en = 1'b1;
          cnt_d = CNT_MAX;
          tgt_d = upd_target;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_WNT;
      end
    end else if (wr_en) begin
      valid_q[up_idx] <= 1'b1;
      cnt_q[up_idx]   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[up_idx]  <= up_tag;
      tgt_q[up_idx]  <= tgt_d;
      kind_q[up_idx] <= kind_d;
    end
  end

  assign mispredict = !reset && upd_valid &&
    ((upd_taken != upd_pred_taken) ||
     (upd_taken && (upd_target != upd_pred_target)));

  assign ras_push = upd_valid && (upd_kind == BP_KIND_CALL);
  assign ras_pop  = upd_valid && (upd_kind == BP_KIND_RET);
  assign ras_data = upd_pc + DATA_LEN'(4);

  bp_ras #(
    .DATA_LEN (DATA_LEN),
    .DEPTH    (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (ras_data),
    .top       (ras_top),
    .empty     (ras_empty)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed plan plus random traffic
// checked against a table/queue reference model.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] if_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [1:0]  upd_kind = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = '0;
  logic        mispredict;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk             (clk),
    .reset           (reset),
    .if_pc           (if_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_kind        (upd_kind),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict)
  );

  typedef struct {
    logic        tk;
    logic [31:0] tg;
    logic        mp;
    string       nm;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  // reference model: one table row per index, RAS as a bounded queue
  bit          m_v   [64];
  int unsigned m_tag [64];
  int unsigned m_tgt [64];
  int          m_cnt [64];
  int          m_kind[64];
  int unsigned m_ras[$];

  function void m_reset();
    for (int i = 0; i < 64; i++) begin
      m_v[i] = 0;
      m_cnt[i] = 1;
    end
    m_ras.delete();
  endfunction

  function void m_predict(input int unsigned pc, output bit tk,
                          output int unsigned tg);
    int unsigned idx;
    idx = (pc >> 2) % 64;
    tk = 0;
    tg = pc + 4;
    if (m_v[idx] && m_tag[idx] == (pc >> 8)) begin
      case (m_kind[idx])
        0: if (m_cnt[idx] >= 2) begin tk = 1; tg = m_tgt[idx]; end
        1, 2: begin tk = 1; tg = m_tgt[idx]; end
        default: if (m_ras.size() > 0) begin
          tk = 1;
          tg = m_ras[$];
        end
      endcase
    end
  endfunction

  function void m_update(input int unsigned pc, input int kind,
                         input bit tk, input int unsigned tgt);
    int unsigned idx;
    bit hit;
    idx = (pc >> 2) % 64;
    hit = m_v[idx] && m_tag[idx] == (pc >> 8);
    if (kind == 0) begin
      if (hit) begin
        m_kind[idx] = 0;
        if (tk) begin
          m_cnt[idx] = (m_cnt[idx] + 1 > 3) ? 3 : m_cnt[idx] + 1;
          m_tgt[idx] = tgt;
        end else begin
          m_cnt[idx] = (m_cnt[idx] - 1 < 0) ? 0 : m_cnt[idx] - 1;
        end
      end else if (tk) begin
        m_v[idx] = 1; m_tag[idx] = pc >> 8; m_tgt[idx] = tgt;
        m_cnt[idx] = 2; m_kind[idx] = 0;
      end
    end else begin
      m_v[idx] = 1; m_tag[idx] = pc >> 8; m_tgt[idx] = tgt;
      m_cnt[idx] = 3; m_kind[idx] = kind;
    end
    if (kind == 2) begin
      m_ras.push_back(pc + 4);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
    end
    if (kind == 3 && m_ras.size() > 0) void'(m_ras.pop_back());
  endfunction

  task automatic step(input logic [31:0] pc, input bit uv,
                      input logic [31:0] upc, input logic [1:0] kind,
                      input bit tk, input logic [31:0] tgt,
                      input bit ptk, input logic [31:0] ptg,
                      input bit rst, input string nm);
    exp_t e;
    bit mtk;
    int unsigned mtg;
    @(posedge clk);
    #1;
    reset = rst;
    if (rst) m_reset();
    if_pc = pc;
    upd_valid = uv;
    upd_pc = upc;
    upd_kind = kind;
    upd_taken = tk;
    upd_target = tgt;
    upd_pred_taken = ptk;
    upd_pred_target = ptg;
    m_predict(pc, mtk, mtg);
    e.tk = mtk;
    e.tg = mtg;
    e.mp = !rst && uv && (tk != ptk || (tk && tgt != ptg));
    e.nm = nm;
    sbq.push_back(e);
    if (uv && !rst) m_update(upc, kind, tk, tgt);
  endtask

  task automatic look(input logic [31:0] pc, input string nm);
    step(pc, 0, 0, 0, 0, 0, 0, 0, 0, nm);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] upc,
                     input logic [1:0] kind, input bit tk,
                     input logic [31:0] tgt, input string nm);
    bit p;
    int unsigned pt;
    m_predict(upc, p, pt);
    step(pc, 1, upc, kind, tk, tgt, p, pt, 0, nm);
  endtask

  // pin the newest expectation to a hand-derived value from the plan
  function void pin(input bit tk, input logic [31:0] tg);
    exp_t e;
    e = sbq.pop_back();
    e.tk = tk;
    e.tg = tg;
    sbq.push_back(e);
  endfunction

  function void pin_mp(input bit mp);
    exp_t e;
    e = sbq.pop_back();
    e.mp = mp;
    sbq.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      total++;
      if (pred_taken !== e.tk || pred_target !== e.tg ||
          mispredict !== e.mp) begin
        bad++;
        $display("FAIL %s: got tk=%0b tg=%h mp=%0b want tk=%0b tg=%h mp=%0b",
                 e.nm, pred_taken, pred_target, mispredict,
                 e.tk, e.tg, e.mp);
      end
    end
  end

  function automatic logic [31:0] rnd_pc();
    return (32'($urandom_range(0, 3)) << 8) |
           (32'($urandom_range(0, 7)) << 2) |
           32'($urandom_range(0, 3));
  endfunction

  initial begin
    int wait_cyc;
    m_reset();
    step(32'h100, 0, 0, 0, 0, 0, 0, 0, 1, "reset_state");
    pin(0, 32'h104);
    pin_mp(0);

    upd(32'h100, 32'h100, BP_KIND_COND, 1, 32'h80, "cond_alloc_same");
    pin(0, 32'h104);
    look(32'h100, "cond_taken");
    pin(1, 32'h80);
    upd(32'h100, 32'h100, BP_KIND_COND, 0, 0, "cond_nt1");
    upd(32'h100, 32'h100, BP_KIND_COND, 0, 0, "cond_nt2");
    look(32'h100, "cond_not_taken");
    pin(0, 32'h104);
    upd(32'h100, 32'h100, BP_KIND_COND, 0, 0, "cond_nt3");
    upd(32'h100, 32'h100, BP_KIND_COND, 1, 32'h80, "cond_t_from0");
    look(32'h100, "cond_floor");
    pin(0, 32'h104);
    for (int i = 0; i < 4; i++)
      upd(32'h0, 32'h100, BP_KIND_COND, 1, 32'h80, "cond_t_sat");
    upd(32'h0, 32'h100, BP_KIND_COND, 0, 0, "cond_nt_after_sat");
    look(32'h100, "cond_ceiling");
    pin(1, 32'h80);

    look(32'h200, "alias_miss");
    pin(0, 32'h204);
    upd(32'h0, 32'h200, BP_KIND_COND, 1, 32'h300, "alias_alloc");
    look(32'h100, "alias_evicted");
    pin(0, 32'h104);
    look(32'h200, "alias_new");
    pin(1, 32'h300);

    upd(32'h0, 32'h10, BP_KIND_CALL, 1, 32'h1000, "call_10");
    upd(32'h0, 32'h20, BP_KIND_CALL, 1, 32'h2000, "call_20");
    upd(32'h0, 32'h50, BP_KIND_RET, 1, 32'h24, "ret_pop_24");
    look(32'h50, "ret_top_14");
    pin(1, 32'h14);
    look(32'h10, "call_btb");
    pin(1, 32'h1000);
    upd(32'h0, 32'h50, BP_KIND_RET, 1, 32'h14, "ret_pop_14");
    look(32'h50, "ret_empty");
    pin(0, 32'h54);

    upd(32'h0, 32'h10, BP_KIND_CALL, 1, 32'h1000, "call5_a");
    upd(32'h0, 32'h20, BP_KIND_CALL, 1, 32'h2000, "call5_b");
    upd(32'h0, 32'h30, BP_KIND_CALL, 1, 32'h3000, "call5_c");
    upd(32'h0, 32'h40, BP_KIND_CALL, 1, 32'h4000, "call5_d");
    upd(32'h0, 32'h60, BP_KIND_CALL, 1, 32'h6000, "call5_e");
    look(32'h50, "ras_top_64");
    pin(1, 32'h64);
    upd(32'h0, 32'h50, BP_KIND_RET, 1, 32'h64, "pop1");
    look(32'h50, "ras_top_44");
    pin(1, 32'h44);
    upd(32'h0, 32'h50, BP_KIND_RET, 1, 32'h44, "pop2");
    upd(32'h0, 32'h50, BP_KIND_RET, 1, 32'h34, "pop3");
    look(32'h50, "ras_top_24");
    pin(1, 32'h24);
    upd(32'h0, 32'h50, BP_KIND_RET, 1, 32'h24, "pop4");
    look(32'h50, "ras_oldest_dropped");
    pin(0, 32'h54);
    upd(32'h0, 32'h50, BP_KIND_RET, 1, 32'h24, "pop5_ignored");
    look(32'h50, "ras_still_empty");
    pin(0, 32'h54);

    step(32'h0, 1, 32'h180, BP_KIND_COND, 1, 32'h90, 1, 32'h80, 0,
         "mispredict_tgt");
    pin_mp(1);
    step(32'h0, 1, 32'h180, BP_KIND_COND, 1, 32'h90, 1, 32'h90, 0,
         "predict_ok");
    pin_mp(0);

    upd(32'h0, 32'h100, BP_KIND_COND, 1, 32'h80, "retrain");
    look(32'h100, "retrained");
    pin(1, 32'h80);
    step(32'h100, 0, 0, 0, 0, 0, 0, 0, 1, "async_reset");
    pin(0, 32'h104);
    look(32'h100, "after_reset");
    pin(0, 32'h104);

    for (int n = 0; n < 2000; n++) begin
      logic [31:0] upc, tgt, ptg;
      logic [1:0]  kind;
      bit          tk, ptk, mtk;
      int unsigned mtg;
      upc  = rnd_pc();
      kind = 2'($urandom_range(0, 3));
      tk   = (kind == BP_KIND_COND) ? 1'($urandom_range(0, 1)) : 1'b1;
      tgt  = {$urandom, 2'b00} & 32'h0000_fffc;
      m_predict(upc, mtk, mtg);
      if ($urandom_range(0, 1) == 1) begin
        ptk = mtk;
        ptg = mtg;
      end else begin
        ptk = 1'($urandom_range(0, 1));
        ptg = (($urandom_range(0, 1) == 1) ? tgt : (tgt ^ 32'h10));
      end
      step(rnd_pc(), ($urandom_range(0, 9) < 7), upc, kind, tk, tgt,
           ptk, ptg, ($urandom_range(0, 199) == 0), "random");
    end

    look(32'h0, "tail");
    wait_cyc = 0;
    while (sbq.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
